// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - two-port ALU issue arbiter; define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins)
module alu_issue_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [3:0]       alu_ctrl,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]  rsp_data
);

    // Issue stage (S1): its operand registers feed the external ALU directly.
    logic             s1_vld_q, s1_vld_d;
    logic             s1_id_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [3:0]       alu_ctrl_q;
    logic [XLEN-1:0]  alu_a_q;
    logic [XLEN-1:0]  alu_b_q;

    // Response stage (S2).
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [XLEN-1:0]  rsp_data_q;

    logic adv1, adv2;
    logic grant0, grant1;
    logic acc0, acc1, accept;
    logic s2_load;

    // S2 can take new data when empty or being drained; S1 can when empty or S2 can.
    assign adv2 = ~rsp_valid_q | rsp_ready;
    assign adv1 = ~s1_vld_q | adv2;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Remembers who won the last accepted handshake; reset to 1 so req0 wins first contention.
    logic last_grant_q;

    // Round-robin state moves only when a request is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= acc1;
        end
    end
`endif

    // Grant selection: a lone requester always wins; contention resolved by policy.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
`else
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif
    end

    // Flush blocks acceptance so nothing enters the pipe in a redirect cycle.
    assign req0_ready = grant0 & adv1 & ~flush;
    assign req1_ready = grant1 & adv1 & ~flush;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign accept     = acc0 | acc1;
    assign s2_load    = s1_vld_q & adv2 & ~flush;

    // Next-state of the two stage-valid flags; flush empties both stages.
    always_comb begin
        s1_vld_d    = s1_vld_q;
        rsp_valid_d = rsp_valid_q;
        if (flush) begin
            s1_vld_d    = 1'b0;
            rsp_valid_d = 1'b0;
        end else begin
            if (adv1) begin
                s1_vld_d = accept;
            end
            if (adv2) begin
                rsp_valid_d = s1_vld_q;
            end
        end
    end

    // Stage-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // S1 payload loads only on an accept; otherwise ALU inputs keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_id_q    <= 1'b0;
            s1_tag_q   <= '0;
            alu_ctrl_q <= 4'b0000;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
        end else if (accept) begin
            s1_id_q    <= acc1;
            s1_tag_q   <= acc1 ? req1_tag : req0_tag;
            alu_ctrl_q <= acc1 ? req1_op  : req0_op;
            alu_a_q    <= acc1 ? req1_a   : req0_a;
            alu_b_q    <= acc1 ? req1_b   : req0_b;
        end
    end

    // S2 captures the ALU result when S1 moves forward; payload holds when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q   <= 1'b0;
            rsp_tag_q  <= '0;
            rsp_data_q <= '0;
        end else if (s2_load) begin
            rsp_id_q   <= s1_id_q;
            rsp_tag_q  <= s1_tag_q;
            rsp_data_q <= alu_result;
        end
    end

    assign alu_ctrl  = alu_ctrl_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - self-checking bench for alu_issue_arbiter
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] data;
    } rsp_t;

    rsp_t q[$];
    int   last_winner = 1;
    bit   acc_last    = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data)
    );

    // Reference ALU: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 OLUI, others distinct.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'd0, $signed(a) < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return a ^ ~b ^ {28'd0, op};
        endcase
    endfunction

    assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_grant(output bit g0, output bit g1);
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            g0 = 1'b1;
`else
            g0 = (last_winner == 1);
`endif
            g1 = !g0;
        end else begin
            g0 = req0_valid;
            g1 = req1_valid;
        end
    endfunction

    task automatic rand_fields();
        req0_op = 4'($urandom_range(0, 15)); req0_a = $urandom; req0_b = $urandom; req0_tag = 4'($urandom);
        req1_op = 4'($urandom_range(0, 15)); req1_a = $urandom; req1_b = $urandom; req1_tag = 4'($urandom);
    endtask

    // One clock: check outputs against the model at the falling edge, then advance the model.
    task automatic tick();
        bit   g0, g1, can, e0, e1, ev;
        rsp_t it;
        @(negedge clk);
        exp_grant(g0, g1);
        can = (q.size() < 2) || rsp_ready;
        e0  = g0 && can && !flush;
        e1  = g1 && can && !flush;
        ev  = (q.size() == 2) || (q.size() == 1 && !acc_last);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_tag", rsp_tag, q[0].tag);
            chk("rsp_data", rsp_data, q[0].data);
        end
        if (flush) begin
            q.delete();
            acc_last = 0;
        end else begin
            if (ev && rsp_ready) void'(q.pop_front());
            if (e0 || e1) begin
                it.id   = e1;
                it.tag  = e1 ? req1_tag : req0_tag;
                it.data = e1 ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b);
                q.push_back(it);
                last_winner = e1 ? 1 : 0;
                acc_last = 1;
            end else begin
                acc_last = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        last_winner = 1;
        acc_last    = 0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #3;
        req0_valid = 0; req1_valid = 0; flush = 0;
        rst_n = 0;
        @(posedge clk); #3;
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1; flush = 0;
        repeat (3) tick();
    endtask

    initial begin
        // Power-on reset values
        #2;
        chk("por_rsp_valid", rsp_valid, 0);
        chk("por_alu_ctrl", alu_ctrl, 0);
        chk("por_rsp_data", rsp_data, 0);
        @(posedge clk); #3;
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;

        // Single ADD from req0: 5 + 7, tag 3
        rsp_ready = 1;
        req0_valid = 1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd3;
        #1;
        chk("t2_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        #1;
        chk("t2_alu_ctrl", alu_ctrl, 4'd0);
        chk("t2_alu_a", alu_a, 32'd5);
        chk("t2_alu_b", alu_b, 32'd7);
        tick();
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_data", rsp_data, 32'd12);
        chk("t2_rsp_id", rsp_id, 0);
        chk("t2_rsp_tag", rsp_tag, 4'd3);
        tick();

        // Both ports streaming from reset: grants alternate starting with req0
        reset_dut();
        rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            #1;
            chk("t3_req0_ready", req0_ready, (i % 2 == 0));
            chk("t3_req1_ready", req1_ready, (i % 2 == 1));
            if (i >= 2) begin
                chk("t3_rsp_valid", rsp_valid, 1);
                chk("t3_rsp_id", rsp_id, (i % 2));
            end
            tick();
        end

        // Backpressure: two accepts then stall, release delivers in order
        drain();
        for (int i = 0; i < 7; i++) begin
            rand_fields();
            req0_valid = 1; req1_valid = 0;
            req0_tag = 4'(i);
            rsp_ready = (i >= 4);
            #1;
            chk("t4_req0_ready", req0_ready, (i < 2) || (i >= 4));
            if (i >= 4) begin
                chk("t4_rsp_valid", rsp_valid, 1);
                chk("t4_rsp_tag", rsp_tag, (i == 4) ? 4'd0 : (i == 5) ? 4'd1 : 4'd4);
            end
            tick();
        end

        // Flush with both stages full and req1 pending
        drain();
        for (int i = 0; i < 2; i++) begin
            rand_fields();
            req1_valid = 1; rsp_ready = 0; req1_tag = 4'(9 + i);
            tick();
        end
        rand_fields();
        req1_tag = 4'd11; flush = 1; rsp_ready = 1;
        #1;
        chk("t5_req1_ready_flush", req1_ready, 0);
        chk("t5_rsp_valid_pre", rsp_valid, 1);
        tick();
        flush = 0; req1_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_rsp_valid_post", rsp_valid, 0);
            tick();
        end

        // Contention for four cycles from reset: policy-dependent grant order
        reset_dut();
        rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bit exp0;
            rand_fields();
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (i % 2 == 0);
`endif
            #1;
            chk("t6_req0_ready", req0_ready, exp0);
            chk("t6_req1_ready", req1_ready, !exp0);
            tick();
        end

        // Asynchronous reset mid-stream with S1 and S2 full
        drain();
        rsp_ready = 0;
        req1_valid = 1; req1_op = 4'd0; req1_a = 32'h1234_5678; req1_b = 32'd3; req1_tag = 4'd7;
        tick();
        req1_a = 32'h0bad_f00d; req1_tag = 4'd5;
        tick();
        req1_valid = 0;
        #2;
        chk("t1_rsp_valid_full", rsp_valid, 1);
        rst_n = 0;
        #1;
        chk("t1_rsp_valid", rsp_valid, 0);
        chk("t1_alu_ctrl", alu_ctrl, 0);
        chk("t1_alu_a", alu_a, 0);
        chk("t1_alu_b", alu_b, 0);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_tag", rsp_tag, 0);
        chk("t1_rsp_data", rsp_data, 0);
        @(posedge clk); #3;
        rst_n = 1;
        model_reset();
        rsp_ready = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_no_stale_rsp", rsp_valid, 0);
            tick();
        end

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            rsp_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
